// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the bus memory responder: default widths, bus
// opcodes (shared with bus_controller) and the FSM state encoding.
package bus_mem_responder_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_BURST_W = 2;

    localparam logic BUS_READ  = 1'b0;
    localparam logic BUS_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Registered handshake outputs, bundled so they update together.
    typedef struct packed {
        logic ack;
        logic valid;
        logic busy;
        logic done;
    } bus_flags_t;

endpackage

// File: rtl/bus_mem_array.sv
// Word-addressed storage: synchronous write, registered read with enable.
// Only the read register is reset; the array contents survive reset.
module bus_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads only when enabled, otherwise holds the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Responder end of the system bus: accepts single or burst reads/writes into
// a local memory, inserting WAIT_CYCLES wait states before the first beat.
//
// state | meaning
// IDLE  | waiting for bus_en; request fields latched on acceptance
// WAIT  | wait states after acceptance (ack high in the first one)
// XFER  | burst+1 data beats, bus_valid high
// DONE  | one-cycle completion, bus_done high
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BURST_W     = DEF_BURST_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_en,
    input  logic               bus_we,
    input  logic [ADDR_W-1:0]  bus_addr,
    input  logic [BURST_W-1:0] bus_burst,
    input  logic [DATA_W-1:0]  bus_wdata,
    output logic [DATA_W-1:0]  bus_rdata,
    output logic               bus_ack,
    output logic               bus_valid,
    output logic               bus_busy,
    output logic               bus_done
);

    localparam logic [3:0]         WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [BURST_W-1:0] BEAT_ONE  = BURST_W'(1);

    state_t             state;
    state_t             next_state;
    bus_flags_t         flags;
    bus_flags_t         flags_d;
    logic               we_q;
    logic [ADDR_W-1:0]  cur_addr;
    logic [BURST_W-1:0] beat_cnt;
    logic [3:0]         wait_cnt;
    logic               accept;
    logic               rd_we;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               wr_en;

    assign accept = (state == IDLE) && bus_en;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the down-counters' terminal count ends WAIT and XFER.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus_en) next_state = (WAIT_CYCLES == 0) ? XFER : WAIT;
            WAIT: if (wait_cnt == 4'd0) next_state = XFER;
            XFER: if (beat_cnt == '0) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output and memory-port decode. Flags are derived from next_state so the
    // registered copies line up with the state they describe. Reads prefetch
    // the address of the upcoming beat; in IDLE that comes straight off the
    // bus because the latches are only loaded on the same edge.
    always_comb begin
        flags_d.ack   = accept;
        flags_d.valid = (next_state == XFER);
        flags_d.busy  = (next_state != IDLE);
        flags_d.done  = (next_state == DONE);

        rd_we = (state == IDLE) ? bus_we : we_q;
        rd_en = (next_state == XFER) && (rd_we == BUS_READ);
        case (state)
            IDLE:    rd_addr = bus_addr;
            XFER:    rd_addr = cur_addr + ADDR_ONE;
            default: rd_addr = cur_addr;
        endcase

        wr_en = (state == XFER) && (we_q == BUS_WRITE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= flags_d;
        end
    end

    // Request latches, beat address and the wait/beat down-counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            cur_addr <= '0;
            beat_cnt <= '0;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            we_q     <= bus_we;
            cur_addr <= bus_addr;
            beat_cnt <= bus_burst;
            wait_cnt <= WAIT_LOAD;
        end else begin
            case (state)
                WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                XFER: begin
                    cur_addr <= cur_addr + ADDR_ONE;
                    if (beat_cnt != '0) beat_cnt <= beat_cnt - BEAT_ONE;
                end
                default: ;
            endcase
        end
    end

    bus_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (cur_addr),
        .wr_data (bus_wdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bus_rdata)
    );

    assign bus_ack   = flags.ack;
    assign bus_valid = flags.valid;
    assign bus_busy  = flags.busy;
    assign bus_done  = flags.done;

endmodule
